vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter.sv | 114 +++++++++++
 tb/tb_vga_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// vga_mem_arbiter: VGA-priority state-RAM arbiter with buffered game writes.
// Rev 1.0
// ============================================================================
module vga_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 800
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vga_re,
  input  logic [AW-1:0]              vga_raddr,
  output logic [DW-1:0]              vga_rdata,
  output logic                       vga_rvalid,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       starve_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rvalid_q, rvalid_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_err_q, starve_err_d;

  logic fifo_empty;
  logic push;
  logic pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    wr_ready   = !reset && (count_q != FULL);
    push       = wr_valid && wr_ready;
    pop        = !reset && !vga_re && !fifo_empty;

    mem_en     = !reset && (vga_re || !fifo_empty);
    mem_we     = pop;
    // Outside VGA reads the address bus parks on the FIFO head.
    mem_addr   = vga_re ? vga_raddr : addr_mem_q[rptr_q];
    mem_wdata  = data_mem_q[rptr_q];

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    rvalid_d = vga_re;

    if (vga_re && !fifo_empty) begin
      starve_cnt_d = (starve_cnt_q == SMAX) ? starve_cnt_q : starve_cnt_q + SW'(1);
    end else begin
      starve_cnt_d = '0;
    end
    starve_err_d = starve_err_q || (starve_cnt_d == SMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rvalid_q     <= 1'b0;
      starve_cnt_q <= '0;
      starve_err_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rvalid_q     <= rvalid_d;
      starve_cnt_q <= starve_cnt_d;
      starve_err_q <= starve_err_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wptr_q] <= wr_addr;
      data_mem_q[wptr_q] <= wr_data;
    end
  end

  assign vga_rdata  = mem_rdata;
  assign vga_rvalid = rvalid_q;
  assign fifo_count = count_q;
  assign starve_err = starve_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_mem_arbiter: scoreboard bench with a RAM model and a queue-based reference.
// Rev 1.0
// ============================================================================
module tb_vga_mem_arbiter;

  localparam int AW         = 10;
  localparam int DW         = 8;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int CW         = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          vga_re;
  logic [AW-1:0] vga_raddr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] fifo_count;
  logic          starve_err;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_re(vga_re), .vga_raddr(vga_raddr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_count(fifo_count), .starve_err(starve_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h12) return 8'h3C;
    return DW'(i * 37 + 11);
  endfunction

  // External synchronous RAM seen by the arbiter.
  logic [DW-1:0] ram [1<<AW];
  logic          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference: ordered pending-write list, golden RAM image, starvation run length.
  logic [DW-1:0] gold [1<<AW];
  logic          gold_ready = 1'b0;
  wr_t           pend   [$];
  wr_t           exp_wq [$];
  logic [DW-1:0] exp_rq [$];
  int            run = 0;
  logic          err_m = 1'b0;

  always @(negedge clk) begin
    int  n;
    wr_t w;
    if (!gold_ready) begin
      for (int i = 0; i < (1 << AW); i++) gold[i] = init_val(i);
      gold_ready = 1'b1;
    end
    if (reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ready", wr_ready, 0);
      pend.delete();
      exp_wq.delete();
      exp_rq.delete();
      run   = 0;
      err_m = 1'b0;
    end else begin
      n = pend.size();
      chk("fifo_count", fifo_count, n);
      chk("wr_ready", wr_ready, (n != DEPTH));
      chk("starve_err", starve_err, err_m);
      if (vga_re) begin
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, vga_raddr);
        exp_rq.push_back(gold[vga_raddr]);
      end else if (n > 0) begin
        w = pend.pop_front();
        chk("drain_mem_en", mem_en, 1);
        chk("drain_mem_we", mem_we, 1);
        gold[w.a] = w.d;
      end else begin
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_we", mem_we, 0);
      end
      if (wr_valid && n != DEPTH) begin
        w.a = wr_addr;
        w.d = wr_data;
        pend.push_back(w);
        exp_wq.push_back(w);
      end
      if (vga_re && n > 0) run = (run < STARVE_MAX) ? run + 1 : run;
      else                 run = 0;
      if (run >= STARVE_MAX) err_m = 1'b1;
    end
  end

  // Monitor: consumes expectations whenever the DUT presents read data or a RAM write.
  always @(negedge clk) begin
    wr_t w;
    #1;
    if (!reset) begin
      if (vga_rvalid) begin
        if (exp_rq.size() == 0) chk("rvalid_unexpected", vga_rvalid, 0);
        else                    chk("vga_rdata", vga_rdata, exp_rq.pop_front());
      end
      if (mem_we) begin
        if (exp_wq.size() == 0) begin
          chk("mem_we_unexpected", mem_we, 0);
        end else begin
          w = exp_wq.pop_front();
          chk("wr_mem_addr", mem_addr, w.a);
          chk("wr_mem_wdata", mem_wdata, w.d);
        end
      end
    end
  end

  task automatic drive(input logic re, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rs);
    @(posedge clk);
    #1;
    vga_re    = re;
    vga_raddr = ra;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    reset     = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    reset = 1'b1; vga_re = 1'b0; vga_raddr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    drive(0, '0, 0, '0, '0, 1);
    drive(0, '0, 0, '0, '0, 1);
    idle(2);

    // Single write into empty FIFO drains on the next cycle.
    drive(0, '0, 1, 10'h005, 8'hA3, 0);
    idle(3);

    // Read of a preloaded location.
    drive(1, 10'h012, 0, '0, '0, 0);
    idle(3);

    // Ten read cycles with six writes offered: FIFO fills, then drains in order.
    for (int i = 0; i < 10; i++)
      drive(1, AW'(i), (i < 6), AW'('h40 + i), DW'('h10 + i), 0);
    idle(6);

    // Reach count 2, then simultaneous push/pop, nine pushes total to wrap pointers.
    for (int i = 0; i < 9; i++)
      drive((i < 2) || (i == 5), 10'h041, 1, AW'('h80 + i), DW'('h50 + i), 0);
    idle(8);

    // Starvation: one pending write held off by continuous reads.
    drive(1, 10'h030, 1, 10'h099, 8'h77, 0);
    for (int i = 0; i < 9; i++) drive(1, 10'h099, 0, '0, '0, 0);
    idle(4);
    drive(1, 10'h099, 0, '0, '0, 0);
    idle(2);

    // Reset with three writes queued must discard them.
    for (int i = 0; i < 3; i++) drive(1, '0, 1, AW'('h200 + i), DW'('hA0 + i), 0);
    drive(0, '0, 0, '0, '0, 1);
    drive(0, '0, 0, '0, '0, 1);
    idle(3);
    drive(1, 10'h200, 0, '0, '0, 0);
    idle(2);

    // Random traffic on a narrow address window to collide reads with pending writes.
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 99) < 55), AW'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 70), AW'($urandom_range(0, 15)),
            DW'($urandom), ($urandom_range(0, 299) == 0));
    idle(10);

    @(negedge clk);
    #2;
    chk("rd_queue_drained", exp_rq.size(), 0);
    chk("wr_queue_drained", exp_wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
